// File: rtl/video_stream_tx_if.sv
// Upstream RGB pixel stream (ready/valid) consumed by video_stream_tx.
interface video_stream_tx_if;
   logic [23:0] s_data;
   logic        s_valid;
   logic        s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/video_stream_tx.sv
// Raster timing generator: pulls RGB pixels from a ready/valid source and emits them with
// coordinates, active flag and syncs. Define TEST_PATTERN_EN for the colour-bar source.
module video_stream_tx #(
   parameter int H_ACTIVE     = 640,
   parameter int H_TOTAL      = 800,
   parameter int H_SYNC_START = 656,
   parameter int H_SYNC_LEN   = 96,
   parameter int V_ACTIVE     = 480,
   parameter int V_TOTAL      = 525,
   parameter int V_SYNC_START = 490,
   parameter int V_SYNC_LEN   = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             clr_underflow,
`ifdef TEST_PATTERN_EN
   input  logic             pattern_sel,
`endif
   video_stream_tx_if.slave s_if,
   output logic [7:0]       r,
   output logic [7:0]       g,
   output logic [7:0]       b,
   output logic [12:0]      col,
   output logic [12:0]      x_count,
   output logic [12:0]      y_count,
   output logic             active,
   output logic             hsync_n,
   output logic             vsync_n,
   output logic             frame_start,
   output logic             underflow
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   localparam logic [12:0] HA    = 13'(H_ACTIVE);
   localparam logic [12:0] HA_M1 = 13'(H_ACTIVE - 1);
   localparam logic [12:0] HT_M1 = 13'(H_TOTAL - 1);
   localparam logic [12:0] HS0   = 13'(H_SYNC_START);
   localparam logic [12:0] HS1   = 13'(H_SYNC_START + H_SYNC_LEN);
   localparam logic [12:0] VA    = 13'(V_ACTIVE);
   localparam logic [12:0] VT_M1 = 13'(V_TOTAL - 1);
   localparam logic [12:0] VS0   = 13'(V_SYNC_START);
   localparam logic [12:0] VS1   = 13'(V_SYNC_START + V_SYNC_LEN);

   function automatic logic [12:0] step_x(input logic [12:0] x);
      return (x == HT_M1) ? 13'd0 : x + 13'd1;
   endfunction

   function automatic logic [12:0] step_y(input logic [12:0] x, input logic [12:0] y);
      if (x != HT_M1) return y;
      return (y == VT_M1) ? 13'd0 : y + 13'd1;
   endfunction

   function automatic logic in_active(input logic [12:0] x, input logic [12:0] y);
      return (x < HA) && (y < VA);
   endfunction

`ifdef TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;

   // Bar order white..black maps to {R,G,B} = {~idx[1], ~idx[2], ~idx[0]}.
   function automatic logic [23:0] bar_rgb(input logic [12:0] x);
      logic [2:0] idx;
      idx = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (x >= 13'(k * BAR_W)) idx = idx + 3'd1;
      end
      return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
   endfunction
`endif

   logic [1:0]  state_q, state_d;
   logic [12:0] x_q, x_d, y_q, y_d, col_q, col_d;
   logic [23:0] rgb_q, rgb_d;
   logic        active_q, active_d;
   logic        hsync_q, hsync_d, vsync_q, vsync_d;
   logic        fs_q, fs_d;
   logic        ready_q, ready_d;
   logic        uf_q, uf_d;
   logic        run_d, frame_end, pat_in, pat_d;
   logic        s_ready_w, take, miss;

   assign frame_end = (x_q == HT_M1) && (y_q == VT_M1);

`ifdef TEST_PATTERN_EN
   logic pat_q;
   assign pat_in = pattern_sel;
`else
   assign pat_in = 1'b0;
`endif

   // ARMED answers s_valid in the same cycle; at the last raster position the
   // continue/stop and source choice for the next frame are taken live.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      s_ready_w = 1'b0;
      case (state_q)
         ST_ARMED: s_ready_w = enable & s_if.s_valid & ~pat_in;
         ST_RUN:   s_ready_w = frame_end ? (enable & ~pat_in) : ready_q;
         default:  s_ready_w = 1'b0;
      endcase
   end

   assign take = s_ready_w & s_if.s_valid;
   assign miss = s_ready_w & ~s_if.s_valid;

   always_comb begin
      state_d = state_q;
      x_d     = '0;
      y_d     = '0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!enable) state_d = ST_IDLE;
            else if (pat_in || s_if.s_valid) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (frame_end && !enable) begin
               state_d = ST_IDLE;
            end else begin
               x_d = step_x(x_q);
               y_d = step_y(x_q, y_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign run_d = (state_d == ST_RUN);
   assign fs_d  = run_d && (x_d == 13'd0) && (y_d == 13'd0);

`ifdef TEST_PATTERN_EN
   assign pat_d = fs_d ? pat_in : pat_q;
`else
   assign pat_d = 1'b0;
`endif

   // Everything below describes the position entered at the next edge; s_ready
   // looks one further ahead so an accepted pixel lands exactly on that position.
   always_comb begin
      active_d = run_d && in_active(x_d, y_d);
      col_d    = (x_d < HA) ? x_d : HA_M1;
      hsync_d  = !(run_d && (x_d >= HS0) && (x_d < HS1));
      vsync_d  = !(run_d && (y_d >= VS0) && (y_d < VS1));
      ready_d  = run_d && in_active(step_x(x_d), step_y(x_d, y_d)) && !pat_d;
      rgb_d    = '0;
      if (take) begin
         rgb_d = s_if.s_data;
      end
`ifdef TEST_PATTERN_EN
      else if (pat_d && active_d) begin
         rgb_d = bar_rgb(x_d);
      end
`endif
      uf_d = miss | (uf_q & ~clr_underflow);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         col_q    <= '0;
         rgb_q    <= '0;
         active_q <= 1'b0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         fs_q     <= 1'b0;
         ready_q  <= 1'b0;
         uf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         col_q    <= col_d;
         rgb_q    <= rgb_d;
         active_q <= active_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         fs_q     <= fs_d;
         ready_q  <= ready_d;
         uf_q     <= uf_d;
      end
   end

`ifdef TEST_PATTERN_EN
   always_ff @(posedge clk) begin
      if (!reset_n) pat_q <= 1'b0;
      else          pat_q <= pat_d;
   end
`endif

   assign s_if.s_ready = s_ready_w;
   assign r            = rgb_q[23:16];
   assign g            = rgb_q[15:8];
   assign b            = rgb_q[7:0];
   assign col          = col_q;
   assign x_count      = x_q;
   assign y_count      = y_q;
   assign active       = active_q;
   assign hsync_n      = hsync_q;
   assign vsync_n      = vsync_q;
   assign frame_start  = fs_q;
   assign underflow    = uf_q;

endmodule

// File: tb/tb_video_stream_tx.sv
// Self-checking bench for video_stream_tx on a reduced raster; pixels are tracked by a
// scoreboard fed at each handshake. Exercises TEST_PATTERN_EN when that macro is defined.
module tb_video_stream_tx;
   localparam int HA     = 16;
   localparam int HT     = 24;
   localparam int HSS    = 18;
   localparam int HSL    = 3;
   localparam int VA     = 6;
   localparam int VT     = 9;
   localparam int VSS    = 7;
   localparam int VSL    = 1;
   localparam int FRAME  = HT * VT;
   localparam int PIXELS = HA * VA;
   localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n = 1'b0;
   logic enable = 1'b0;
   logic clr_underflow = 1'b0;
`ifdef TEST_PATTERN_EN
   logic pattern_sel = 1'b0;
`endif
   video_stream_tx_if s_if ();
   logic [7:0]  r, g, b;
   logic [12:0] col, x_count, y_count;
   logic        active, hsync_n, vsync_n, frame_start, underflow;

   video_stream_tx #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
      .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .clr_underflow(clr_underflow),
`ifdef TEST_PATTERN_EN
      .pattern_sel(pattern_sel),
`endif
      .s_if(s_if),
      .r(r), .g(g), .b(b),
      .col(col), .x_count(x_count), .y_count(y_count),
      .active(active), .hsync_n(hsync_n), .vsync_n(vsync_n),
      .frame_start(frame_start), .underflow(underflow)
   );

   int vectors = 0;
   int fails = 0;
   int cyc = 0;
   int consumed = 0;

   // Stimulus variables applied at the next negedge.
   logic        rst = 1'b1, en = 1'b0, sv = 1'b0, clr = 1'b0, psel = 1'b0;
   logic [23:0] sd = 24'h102030;

   // Behavioural model of the raster as seen in the current cycle.
   int          mstate = 0, mx = 0, my = 0;
   logic        muf = 1'b0, mpat = 1'b0, mknown = 1'b0;
   logic [23:0] sb [$];
   int          fs_cyc [$];
   int          fs_cons [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic act(input int x, input int y);
      return (x < HA) && (y < VA);
   endfunction

   task automatic tick();
      int          nx, ny, exp_col;
      logic        run, fe, exp_ready, exp_act, exp_hs, exp_vs, exp_fs, uf_next;
      logic [23:0] exp_pix;
      @(negedge clk);
      reset_n       = ~rst;
      enable        = en;
      clr_underflow = clr;
      s_if.s_valid  = sv;
      s_if.s_data   = sd;
`ifdef TEST_PATTERN_EN
      pattern_sel   = psel;
`endif
      #1;
      cyc++;
      run = (mstate == 2);
      nx  = (mx == HT - 1) ? 0 : mx + 1;
      ny  = (mx == HT - 1) ? ((my == VT - 1) ? 0 : my + 1) : my;
      fe  = run && (mx == HT - 1) && (my == VT - 1);
      case (mstate)
         1:       exp_ready = en && sv && !psel;
         2:       exp_ready = fe ? (en && !psel) : (act(nx, ny) && !mpat);
         default: exp_ready = 1'b0;
      endcase
      exp_act = run && act(mx, my);
      exp_pix = 24'h0;
      if (exp_act) begin
         if (mpat) exp_pix = BARS[mx / (HA / 8)];
         else if (sb.size() > 0) exp_pix = sb.pop_front();
         else check("scoreboard_underrun", 64'(sb.size()), 64'd1);
      end
      exp_col = (mx < HA) ? mx : HA - 1;
      exp_hs  = !(run && (mx >= HSS) && (mx < HSS + HSL));
      exp_vs  = !(run && (my >= VSS) && (my < VSS + VSL));
      exp_fs  = run && (mx == 0) && (my == 0);
      if (mknown) begin
         check("pixel", 64'({r, g, b}), 64'(exp_pix));
         check("coord", 64'({x_count, y_count, col}), 64'({13'(mx), 13'(my), 13'(exp_col)}));
         check("flags", 64'({active, hsync_n, vsync_n, frame_start, underflow, s_if.s_ready}),
               64'({exp_act, exp_hs, exp_vs, exp_fs, muf, exp_ready}));
      end
      if (frame_start === 1'b1) begin
         fs_cyc.push_back(cyc);
         fs_cons.push_back(consumed);
      end
      if (s_if.s_valid === 1'b1 && s_if.s_ready === 1'b1) consumed++;

      uf_next = (exp_ready && !sv) || (muf && !clr);
      if (exp_ready) begin
         sb.push_back(sv ? sd : 24'h0);
         if (sv) sd = sd + 24'h010307;
      end
      if (rst) begin
         mstate = 0; mx = 0; my = 0; muf = 1'b0; mpat = 1'b0; mknown = 1'b1;
         sb.delete();
      end else begin
         muf = uf_next;
         case (mstate)
            0: if (en) mstate = 1;
            1: begin
               if (!en) mstate = 0;
               else if (psel || sv) begin mstate = 2; mpat = psel; end
            end
            default: begin
               if (fe && !en) begin mstate = 0; mx = 0; my = 0; end
               else begin
                  if (fe) mpat = psel;
                  mx = nx; my = ny;
               end
            end
         endcase
      end
   endtask

   task automatic run_until(input int x, input int y, input int budget);
      int n = 0;
      while (!(mstate == 2 && mx == x && my == y) && n < budget) begin
         tick();
         n++;
      end
      check("reach_position", 64'(n < budget), 64'd1);
   endtask

   initial begin
      // Reset, then continuous stream with incrementing data.
      rst = 1'b1; repeat (3) tick();
      rst = 1'b0; en = 1'b1; sv = 1'b1;
      repeat (2 * FRAME + 60) tick();
      check("frame_starts_seen", 64'(fs_cyc.size() >= 2), 64'd1);
      if (fs_cyc.size() >= 2) begin
         check("frame_period", 64'(fs_cyc[1] - fs_cyc[0]), 64'(FRAME));
         check("pixels_per_frame", 64'(fs_cons[1] - fs_cons[0]), 64'(PIXELS));
      end

      // Three-cycle upstream dropout: positions x=5..7 of line 2 go black.
      run_until(4, 2, 2 * FRAME);
      sv = 1'b0; repeat (3) tick();
      sv = 1'b1; repeat (40) tick();
      clr = 1'b1; tick();
      clr = 1'b0; repeat (10) tick();

      // Mid-frame disable: frame completes, then IDLE.
      run_until(8, 3, 2 * FRAME);
      en = 1'b0;
      begin
         int n = 0;
         while (mstate != 0 && n < 2 * FRAME) begin tick(); n++; end
         check("reach_idle", 64'(n < 2 * FRAME), 64'd1);
      end
      repeat (5) tick();
      en = 1'b1; sv = 1'b0; repeat (50) tick();
      sv = 1'b1; repeat (30) tick();

      // Underflow then mid-frame reset: everything returns to reset values.
      run_until(3, 4, 2 * FRAME);
      sv = 1'b0; tick();
      sv = 1'b1;
      run_until(10, 4, FRAME);
      rst = 1'b1; tick();
      rst = 1'b0; en = 1'b0; repeat (5) tick();

`ifdef TEST_PATTERN_EN
      // Colour bars for one frame, then back to the upstream stream.
      en = 1'b1; psel = 1'b1; sv = 1'b1;
      repeat (FRAME + 10) tick();
      psel = 1'b0;
      repeat (FRAME + 20) tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule

// File: doc/video_stream_tx.md
Name: video_stream_tx

Overview:
- Transmit-side timing generator for the pixel stream consumed by the edge/cartoon filter chain.
- Pulls RGB pixels from an upstream ready/valid source (camera FIFO).
- Emits them as a raster with `col`/`x_count`/`y_count` coordinates, active flag and sync strobes, which downstream row-buffer filters use for line-buffer addressing and shift enables.
- Also aligns frame start to data availability and flags upstream underflow.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, clocks per line including blanking
- H_SYNC_START, 656, `x_count` at which `hsync_n` falls
- H_SYNC_LEN, 96, hsync pulse width in clocks
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame including blanking
- V_SYNC_START, 490, `y_count` at which `vsync_n` falls
- V_SYNC_LEN, 2, vsync pulse width in lines

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  synchronous active-low reset
- enable  in  1  run request; sampled at frame boundaries
- s_data  in  24  upstream pixel {R[23:16],G[15:8],B[7:0]}
- s_valid  in  1  upstream pixel available
- s_ready  out  1  pixel accepted this cycle when s_valid&s_ready
- r, g, b  out  8 each  output pixel
- col  out  13  active column index
- x_count  out  13  horizontal counter 0..H_TOTAL-1
- y_count  out  13  vertical counter 0..V_TOTAL-1
- active  out  1  (x_count<H_ACTIVE)&&(y_count<V_ACTIVE)
- hsync_n, vsync_n  out  1 each  active-low syncs
- frame_start  out  1  one-cycle pulse with coordinate (0,0)
- underflow  out  1  sticky; set when active pixel needed and s_valid low
- clr_underflow  in  1  clears underflow

Behaviour:
- All outputs are registered. Reset (`reset_n`=0 at a clk edge) gives:
  - `r`/`g`/`b`/`col`/`x_count`/`y_count` = 0
  - `active`/`s_ready`/`frame_start`/`underflow` = 0
  - `hsync_n`/`vsync_n` = 1
  - state IDLE
- Reset mid-frame behaves identically; no partial-frame completion.
- States:
  - IDLE: counters held at 0, `s_ready`=0, syncs high. `enable`=1 -> ARMED.
  - ARMED: waits for `s_valid`=1; then `s_ready`=1 for that cycle, pixel consumed, -> RUN. Next cycle outputs coordinate (0,0) with `frame_start`=1 and `active`=1. `enable`=0 in ARMED -> IDLE.
  - RUN: `x_count` increments every clk; at H_TOTAL-1 it wraps to 0 and `y_count` increments; at (H_TOTAL-1,V_TOTAL-1) both wrap and `frame_start` pulses for (0,0). If `enable`=0 when wrapping at end of frame -> IDLE. Mid-frame deassertion is ignored until the frame completes.
- `s_ready` in RUN = 1 iff the next raster position is active. A pixel accepted at cycle t appears on `r`,`g`,`b` at t+1 together with that position's coordinates (latency 1).
- Underflow: `s_ready`=1 with `s_valid`=0 outputs `r`/`g`/`b`=0 for that position and sets `underflow`. Raster timing never stalls. `clr_underflow` and a new underflow in the same cycle -> `underflow` stays 1.
- Blanking outputs `r`/`g`/`b`=0.
- `col` = `x_count` while `x_count`<H_ACTIVE; holds H_ACTIVE-1 during horizontal blanking; returns to 0 with `x_count`.
- `hsync_n`=0 for H_SYNC_START <= `x_count` < H_SYNC_START+H_SYNC_LEN.
- `vsync_n`=0 for V_SYNC_START <= `y_count` < V_SYNC_START+V_SYNC_LEN, for whole lines.
- All coordinate/sync outputs are aligned to the same cycle as `r`/`g`/`b`.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined:
  - Adds input `pattern_sel` (1 bit), sampled only at `frame_start`.
  - When latched 1, `s_ready` is held 0 and no upstream pixels are consumed.
  - ARMED does not wait for `s_valid`; it goes to RUN on the next clk.
  - Active pixels are 8 vertical colour bars of width H_ACTIVE/8: white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF/8'h00).
  - `underflow` is not set.
- Undefined: no `pattern_sel` port; upstream stream only.

Test Plan:
1. Reset, `enable`=1, `s_valid`=1 constant, incrementing data -> `frame_start` at (0,0). First output equals first s_data word. `col` reaches 639 and holds through x=640..799. 307200 pixels consumed per frame. Frame period exactly 420000 clks.
2. Sync timing -> `hsync_n` low for x=656..751 on every line; `vsync_n` low for y=490..491; both high during reset.
3. Drop `s_valid` for 3 cycles at (100,10) -> `r`/`g`/`b`=0 at x=100..102, `underflow`=1 and stays set. `clr_underflow` pulse -> 0. Raster timing unchanged.
4. `enable`=0 at (320,200) -> frame completes to (799,524), then IDLE with counters 0. `enable`=1 with `s_valid`=0 for 50 cycles -> remains ARMED, `s_ready`=0 until `s_valid` rises.
5. `reset_n`=0 for one clk at (400,300) -> next cycle all outputs at reset values, state IDLE, `underflow` cleared.
6. (TEST_PATTERN_EN) `pattern_sel`=1 at `frame_start` -> x=0..79 `r`/`g`/`b`=FF/FF/FF, x=80..159 FF/FF/00, x=560..639 00/00/00. `s_ready` stays 0.
